data_mem_copy_engine: RTL

Block-copy initiator for the 16-word × 16-bit data memory. It accepts a source address, destination address and length, then performs read-then-write sequences on the memory port until the block is copied, with a running checksum. It sits between the control unit and the data memory, and owns the memory port (MemWrite/Addr/In) while busy; the control unit muxes it in via Busy.

---
 rtl/data_mem_copy_engine_pkg.sv | 8 +
 rtl/data_mem_copy_engine.sv | 84 ++++++++
 2 files changed

// File: rtl/data_mem_copy_engine_pkg.sv
// data_mem_copy_engine_pkg: shared widths, memory size and copy-engine state encoding
package data_mem_copy_engine_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int LEN_W = 5;
  localparam int MEM_WORDS = 16;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/data_mem_copy_engine.sv
// data_mem_copy_engine: ascending read-then-write block copy over the data memory port with running checksum
module data_mem_copy_engine
  import data_mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = data_mem_copy_engine_pkg::ADDR_W,
  parameter int DATA_W = data_mem_copy_engine_pkg::DATA_W,
  parameter int LEN_W = data_mem_copy_engine_pkg::LEN_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Len,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Checksum,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0] remaining, len_clamped;
  logic [DATA_W-1:0] hold;
  assign len_clamped = (Len > LEN_W'(MEM_WORDS)) ? LEN_W'(MEM_WORDS) : Len;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      remaining <= '0;
      hold <= '0;
      Checksum <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Start) begin
        src_ptr <= SrcAddr;
        dst_ptr <= DstAddr;
        remaining <= len_clamped;
        Checksum <= '0;
      end
      if (state == READ) begin
        hold <= RdData;
        src_ptr <= src_ptr + 1'b1;
      end
      // the word is written at this edge even when aborting, so it is counted too
      if (state == WRITE) begin
        dst_ptr <= dst_ptr + 1'b1;
        remaining <= remaining - 1'b1;
        Checksum <= Checksum + hold;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    Busy = 1'b0;
    Done = 1'b0;
    MemWrite = 1'b0;
    Addr = '0;
    WrData = hold;
    unique case (state)
      IDLE: state_nxt = Start ? ((len_clamped == '0) ? DONE : READ) : IDLE;
      READ: begin
        Busy = 1'b1;
        Addr = src_ptr;
        state_nxt = Abort ? IDLE : WRITE;
      end
      WRITE: begin
        Busy = 1'b1;
        MemWrite = 1'b1;
        Addr = dst_ptr;
        state_nxt = Abort ? IDLE : ((remaining > LEN_W'(1)) ? READ : DONE);
      end
      DONE: begin
        Done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
